// File: rtl/idx_pkg.sv
// -----------------------------------------------------------------------------
// idx_pkg
// Shared definitions for the index bound checker.
//   IDX_DATA_W  : default index / limit width
//   IDX_CNT_W   : default out-of-range counter width
//   idx_stage_t : one pipeline stage record (valid, x, limit, oor)
// Optional feature macro used by idx_bound_check: IDX_BOUND_SATURATE_EN.
// -----------------------------------------------------------------------------
package idx_pkg;

    localparam int IDX_DATA_W = 32;
    localparam int IDX_CNT_W  = 16;

    typedef struct packed {
        logic                  valid;
        logic [IDX_DATA_W-1:0] x;
        logic [IDX_DATA_W-1:0] limit;
        logic                  oor;
    } idx_stage_t;

endpackage

// File: rtl/idx_bound_check_if.sv
// -----------------------------------------------------------------------------
// idx_bound_check_if
// Handshake bundle of the index bound checker.
//   ivalid/iready/x/limit          : input beat (upstream -> block)
//   ovalid/oready/y/oor/oor_count  : output beat (block -> downstream)
// Modports:
//   master : the surroundings (drive inputs and oready, observe outputs)
//   slave  : the idx_bound_check block itself
// -----------------------------------------------------------------------------
interface idx_bound_check_if
    import idx_pkg::*;
#(
    parameter int DATA_W = IDX_DATA_W,
    parameter int CNT_W  = IDX_CNT_W
) ();

    logic              ivalid;
    logic              iready;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] limit;
    logic              ovalid;
    logic              oready;
    logic [DATA_W-1:0] y;
    logic              oor;
    logic [CNT_W-1:0]  oor_count;

    modport master (
        output ivalid, x, limit, oready,
        input  iready, ovalid, y, oor, oor_count
    );

    modport slave (
        input  ivalid, x, limit, oready,
        output iready, ovalid, y, oor, oor_count
    );

endinterface

// File: rtl/idx_pipe_reg.sv
// -----------------------------------------------------------------------------
// idx_pipe_reg
// One pipeline stage holding an idx_stage_t record.
//   clock : rising-edge clock
//   reset : synchronous active-high, clears the valid bit only
//   en    : load enable; when high the stage takes d.valid
//   d     : incoming record
//   q     : stored record
// The payload is only overwritten by a valid record, so a bubble clears the
// valid bit but leaves the last payload in place.
// -----------------------------------------------------------------------------
module idx_pipe_reg
    import idx_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  idx_stage_t d,
    output idx_stage_t q
);

    logic                  valid_d, valid_q;
    logic [IDX_DATA_W-1:0] x_d, x_q;
    logic [IDX_DATA_W-1:0] limit_d, limit_q;
    logic                  oor_d, oor_q;

    always_comb begin
        valid_d = valid_q;
        x_d     = x_q;
        limit_d = limit_q;
        oor_d   = oor_q;
        if (en) begin
            valid_d = d.valid;
            if (d.valid) begin
                x_d     = d.x;
                limit_d = d.limit;
                oor_d   = d.oor;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
        x_q     <= x_d;
        limit_q <= limit_d;
        oor_q   <= oor_d;
    end

    assign q = '{valid: valid_q, x: x_q, limit: limit_q, oor: oor_q};

endmodule

// File: rtl/idx_bound_check.sv
// -----------------------------------------------------------------------------
// idx_bound_check
// Two-stage bounds check on a doubled index coming from the index shifter.
// Stage 1 registers x/limit together with the unsigned compare x >= limit,
// stage 2 holds the beat for output and selects y.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous active-high; drops in-flight beats, clears oor_count
//   bus   : idx_bound_check_if.slave
//             ivalid/iready/x/limit in, ovalid/oready/y/oor/oor_count out
// Configuration macro:
//   IDX_BOUND_SATURATE_EN defined   : out-of-range beats give y = limit-1
//                                     (y = 0 when limit = 0)
//   IDX_BOUND_SATURATE_EN undefined : out-of-range beats pass y = x, only oor
//                                     marks them
// oor_count counts delivered out-of-range beats and sticks at all-ones.
// -----------------------------------------------------------------------------
module idx_bound_check
    import idx_pkg::*;
#(
    parameter int DATA_W = IDX_DATA_W,
    parameter int CNT_W  = IDX_CNT_W
) (
    input logic              clock,
    input logic              reset,
    idx_bound_check_if.slave bus
);

    // The stage record in idx_pkg is sized by IDX_DATA_W.
    generate
        if (DATA_W != IDX_DATA_W) begin : g_width_check
            $error("idx_bound_check: DATA_W must equal idx_pkg::IDX_DATA_W");
        end
    endgenerate

    idx_stage_t       stage_p0;
    idx_stage_t       stage_p1;
    idx_stage_t       stage_p2;
    logic             advance;
    logic             iready;
    logic             xfer;
    logic [DATA_W-1:0] y;
    logic             oor;
    logic [CNT_W-1:0] oor_count_d, oor_count_q;

`ifdef IDX_BOUND_SATURATE_EN
    function automatic logic [DATA_W-1:0] sat_idx(input logic [DATA_W-1:0] lim);
        sat_idx = (lim == '0) ? '0 : lim - DATA_W'(1);
    endfunction
`endif

    // Stage 2 moves whenever its beat leaves or it is empty; stage 1 accepts
    // whenever it can hand its own beat on or is empty.
    always_comb begin
        advance = bus.oready | ~stage_p2.valid;
        iready  = advance | ~stage_p1.valid;
    end

    // ---- input -> stage 1: compare ----
    always_comb begin
        stage_p0 = '{valid: bus.ivalid, x: bus.x, limit: bus.limit,
                     oor: (bus.x >= bus.limit)};
    end

    idx_pipe_reg u_stage_p1 (
        .clock (clock),
        .reset (reset),
        .en    (iready),
        .d     (stage_p0),
        .q     (stage_p1)
    );

    // ---- stage 1 -> stage 2: hold for output ----
    idx_pipe_reg u_stage_p2 (
        .clock (clock),
        .reset (reset),
        .en    (advance),
        .d     (stage_p1),
        .q     (stage_p2)
    );

    // ---- stage 2 -> output: select ----
    always_comb begin
        y   = '0;
        oor = 1'b0;
        if (stage_p2.valid) begin
            oor = stage_p2.oor;
            y   = stage_p2.x;
`ifdef IDX_BOUND_SATURATE_EN
            if (stage_p2.oor) begin
                y = sat_idx(stage_p2.limit);
            end
`endif
        end
    end

`ifndef IDX_BOUND_SATURATE_EN
    // limit is only needed for the saturating select.
    logic unused_limit_p2;
    assign unused_limit_p2 = ^stage_p2.limit;
`endif

    assign xfer = stage_p2.valid & bus.oready;

    always_comb begin
        oor_count_d = oor_count_q;
        if (xfer && stage_p2.oor && (oor_count_q != '1)) begin
            oor_count_d = oor_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            oor_count_q <= '0;
        end else begin
            oor_count_q <= oor_count_d;
        end
    end

    assign bus.iready    = iready;
    assign bus.ovalid    = stage_p2.valid;
    assign bus.y         = y;
    assign bus.oor       = oor;
    assign bus.oor_count = oor_count_q;

endmodule

// File: tb/tb_idx_bound_check.sv
// -----------------------------------------------------------------------------
// tb_idx_bound_check
// Directed bench for idx_bound_check. u_dut uses the default counter width,
// u_dut_c2 a 2-bit counter to exercise counter saturation.
// Expected y for out-of-range beats follows IDX_BOUND_SATURATE_EN.
// -----------------------------------------------------------------------------
module tb_idx_bound_check;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

`ifdef IDX_BOUND_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    idx_bound_check_if #(.DATA_W(32), .CNT_W(16)) bus1 ();
    idx_bound_check_if #(.DATA_W(32), .CNT_W(2))  bus2 ();

    idx_bound_check #(.DATA_W(32), .CNT_W(16)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    idx_bound_check #(.DATA_W(32), .CNT_W(2)) u_dut_c2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Single beat through an otherwise empty pipe with oready held high.
    task automatic beat(input logic [31:0] bx, input logic [31:0] bl,
                        input logic [31:0] exp_y, input bit exp_oor,
                        input logic [15:0] exp_cnt, input string tag);
        bus1.ivalid = 1'b1;
        bus1.x      = bx;
        bus1.limit  = bl;
        cyc();
        bus1.ivalid = 1'b0;
        chk({tag, "_lat1_ovalid"}, 64'(bus1.ovalid), 64'd0);
        cyc();
        chk({tag, "_ovalid"}, 64'(bus1.ovalid), 64'd1);
        chk({tag, "_y"},      64'(bus1.y),      64'(exp_y));
        chk({tag, "_oor"},    64'(bus1.oor),    64'(exp_oor));
        cyc();
        chk({tag, "_cnt"},    64'(bus1.oor_count), 64'(exp_cnt));
        chk({tag, "_drained"}, 64'(bus1.ovalid), 64'd0);
    endtask

    logic [31:0] exp_q [4];
    int acc;
    int out;

    initial begin
        reset       = 1'b1;
        bus1.ivalid = 1'b0;
        bus1.x      = '0;
        bus1.limit  = '0;
        bus1.oready = 1'b1;
        bus2.ivalid = 1'b0;
        bus2.x      = '0;
        bus2.limit  = '0;
        bus2.oready = 1'b1;

        // Reset state
        cyc();
        cyc();
        chk("rst_ovalid", 64'(bus1.ovalid),    64'd0);
        chk("rst_y",      64'(bus1.y),         64'd0);
        chk("rst_oor",    64'(bus1.oor),       64'd0);
        chk("rst_cnt",    64'(bus1.oor_count), 64'd0);
        chk("rst_cnt_c2", 64'(bus2.oor_count), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_iready", 64'(bus1.iready), 64'd1);

        // Single beats: in range, out of range, limit 0, boundaries
        beat(32'd6,          32'd10,         32'd6,                           1'b0, 16'd0, "in_range");
        beat(32'd20,         32'd10,         SAT ? 32'd9 : 32'd20,            1'b1, 16'd1, "oor_20_10");
        beat(32'd0,          32'd0,          32'd0,                           1'b1, 16'd2, "lim0");
        beat(32'd9,          32'd10,         32'd9,                           1'b0, 16'd2, "edge_9_10");
        beat(32'd10,         32'd10,         SAT ? 32'd9 : 32'd10,            1'b1, 16'd3, "edge_10_10");
        beat(32'h8000_0000,  32'd5,          SAT ? 32'd4 : 32'h8000_0000,     1'b1, 16'd4, "unsigned_big");
        beat(32'd3,          32'hFFFF_FFFF,  32'd3,                           1'b0, 16'd4, "lim_max");

        // Back-to-back beats with oready low during cycles 2..5
        exp_q[0] = 32'd100;
        exp_q[1] = 32'd101;
        exp_q[2] = 32'd102;
        exp_q[3] = 32'd103;
        acc = 0;
        out = 0;
        for (int c = 1; c <= 12; c++) begin
            bus1.oready = !(c >= 2 && c <= 5);
            if (acc < 4) begin
                bus1.ivalid = 1'b1;
                bus1.x      = exp_q[acc];
                bus1.limit  = 32'd1000;
            end else begin
                bus1.ivalid = 1'b0;
            end
            #1;
            if (c == 3) begin
                chk("stall_iready",  64'(bus1.iready), 64'd0);
                chk("stall_accepts", 64'(acc),         64'd2);
            end
            if (c >= 3 && c <= 5) begin
                chk("stall_ovalid", 64'(bus1.ovalid), 64'd1);
                chk("stall_y_hold", 64'(bus1.y),      64'd100);
            end
            if (bus1.ovalid && bus1.oready) begin
                if (out < 4) chk("order_y", 64'(bus1.y), 64'(exp_q[out]));
                out++;
            end
            if (bus1.ivalid && bus1.iready) acc++;
            cyc();
        end
        bus1.ivalid = 1'b0;
        bus1.oready = 1'b1;
        chk("stall_delivered", 64'(out), 64'd4);
        chk("stall_accepted",  64'(acc), 64'd4);

        // 2-bit counter saturation with 5 out-of-range beats
        for (int c = 0; c < 8; c++) begin
            bus2.ivalid = (c < 5);
            bus2.x      = 32'd50;
            bus2.limit  = 32'd10;
            cyc();
            if (c == 2) chk("c2_cnt_first", 64'(bus2.oor_count), 64'd1);
            if (c == 4) chk("c2_cnt_reach", 64'(bus2.oor_count), 64'd3);
        end
        chk("c2_cnt_hold", 64'(bus2.oor_count), 64'd3);

        // Reset with both stages full
        bus1.oready = 1'b0;
        bus1.ivalid = 1'b1;
        bus1.x      = 32'd7;
        bus1.limit  = 32'd100;
        cyc();
        bus1.x = 32'd8;
        cyc();
        bus1.ivalid = 1'b0;
        #1;
        chk("full_ovalid", 64'(bus1.ovalid), 64'd1);
        chk("full_y",      64'(bus1.y),      64'd7);
        chk("full_iready", 64'(bus1.iready), 64'd0);
        reset = 1'b1;
        cyc();
        chk("midrst_ovalid", 64'(bus1.ovalid),    64'd0);
        chk("midrst_y",      64'(bus1.y),         64'd0);
        chk("midrst_oor",    64'(bus1.oor),       64'd0);
        chk("midrst_cnt",    64'(bus1.oor_count), 64'd0);
        chk("midrst_cnt_c2", 64'(bus2.oor_count), 64'd0);
        reset       = 1'b0;
        bus1.oready = 1'b1;
        #1;
        chk("midrst_iready", 64'(bus1.iready), 64'd1);
        for (int c = 0; c < 3; c++) begin
            cyc();
            chk("no_stale_ovalid", 64'(bus1.ovalid), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/idx_bound_check.md
IDX_BOUND_CHECK -- requirements
Module: idx_bound_check

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the index and limit width.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the out-of-range counter.
REQ-003 SHALL have port clock  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port ivalid  input  1  input beat valid.
REQ-006 SHALL have port iready  output  1  block accepts the input beat this cycle.
REQ-007 SHALL have port x  input  DATA_W  doubled index from the upstream index shifter.
REQ-008 SHALL have port limit  input  DATA_W  buffer length, sampled together with x.
REQ-009 SHALL have port ovalid  output  1  output beat valid.
REQ-010 SHALL have port oready  input  1  downstream accepts the output beat.
REQ-011 SHALL have port y  output  DATA_W  bounded index.
REQ-012 SHALL have port oor  output  1  beat's x was out of range (x >= limit, unsigned).
REQ-013 SHALL have port oor_count  output  CNT_W  number of out-of-range beats delivered, saturating.

Function
REQ-014 SHALL be a 2-stage pipeline (S1 compare, S2 select/output), each stage with its own valid bit.
REQ-015 SHALL transfer an input beat when ivalid and iready are both high in the same cycle.
REQ-016 SHALL transfer an output beat when ovalid and oready are both high in the same cycle.
REQ-017 SHALL define advance = oready | ~S2.valid, and SHALL drive iready = advance | ~S1.valid (combinational).
REQ-018 SHALL load S2 from S1 when advance is high, and SHALL load S1 from the input when iready is high.
REQ-019 SHALL present a beat on y/oor/ovalid exactly 2 cycles after acceptance when oready is held high, sustaining 1 beat per cycle.
REQ-020 SHALL, while oready is low with both stages full, hold y, oor and ovalid stable and deassert iready; no beat may be lost or duplicated.
REQ-021 SHALL compute oor in S1 as unsigned x >= limit.
REQ-022 SHALL, with limit = 0, flag every beat oor = 1.
REQ-023 SHALL drive y = x when oor = 0.
REQ-024 SHALL increment oor_count by 1 on each output transfer with oor = 1, and SHALL hold it at all-ones once reached (no wrap).
REQ-025 SHALL clear S1/S2 valid bits but not their data when ivalid is low at the load point.

Reset
REQ-026 SHALL, while reset is high, drive ovalid = 0, y = 0, oor = 0 and oor_count = 0, and SHALL clear both stage valid bits.
REQ-027 SHALL force iready = 1 from the first cycle after reset deasserts.
REQ-028 SHALL, when reset is asserted mid-operation, discard any in-flight beats without delivering them.

Configuration
REQ-029 SHALL use macro IDX_BOUND_SATURATE_EN to select out-of-range handling.
REQ-030 SHALL, when IDX_BOUND_SATURATE_EN is defined, drive y = limit-1 for out-of-range beats, and y = 0 when limit = 0.
REQ-031 SHALL, when IDX_BOUND_SATURATE_EN is undefined, pass y = x unchanged for out-of-range beats, with only oor flagging them.

Structure
REQ-032 SHALL place DATA_W/CNT_W defaults and the stage record typedef (valid, x, limit, oor) in shared package idx_pkg.
REQ-033 SHALL factor the per-stage valid/data/enable handling into one sub-module, idx_pipe_reg, instantiated twice.

Verification
REQ-034 SHALL cover: reset, then x=6, limit=10, oready=1 -> y=6, oor=0 two cycles later; oor_count=0.
REQ-035 SHALL cover: x=20, limit=10 -> oor=1; y=9 with the macro defined, y=20 without; oor_count=1.
REQ-036 SHALL cover: limit=0, x=0 -> oor=1; y=0 with the macro defined.
REQ-037 SHALL cover: 4 back-to-back beats with oready low for cycles 2-5 -> iready low after 2 accepts, all 4 delivered in order, no duplicates.
REQ-038 SHALL cover: CNT_W=2 with 5 out-of-range beats -> oor_count=3 and holds.
REQ-039 SHALL cover: reset high with both stages full -> ovalid=0 next cycle, no stale beat after release.
